// File: rtl/bus_cycle_pkg.sv
// Shared state encoding, cycle-type codes and beat-plan helpers for the
// external bus-cycle sequencer.
package bus_cycle_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4, S_HOLD
  } state_t;

  localparam logic [1:0] CT_MEM  = 2'd0;
  localparam logic [1:0] CT_IO   = 2'd1;
  localparam logic [1:0] CT_INTA = 2'd2;

  // Only odd or byte-split words on a wide bus, and every word on a narrow bus, need two beats
  function automatic logic [1:0] beat_count(input int bus_w, input logic inta,
                                            input logic byte_op, input logic a0);
    if (inta)                 return 2'd2;
    if (byte_op)              return 2'd1;
    if (bus_w == 16 && !a0)   return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic beat_lane(input int bus_w, input logic inta,
                                     input logic a0, input logic beat);
    if (bus_w != 16 || inta) return 1'b0;
    return a0 ^ beat;
  endfunction

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// Core request port plus multiplexed external bus pins of the sequencer.
interface bus_cycle_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int BUS_W  = 8
);
  localparam int CORE_W = 16;
  localparam int LANES  = BUS_W / 8;

  logic              req;
  logic [1:0]        ctype;
  logic              we;
  logic              byte_op;
  logic [ADDR_W-1:0] addr;
  logic [CORE_W-1:0] wdata;
  logic [CORE_W-1:0] rdata;
  logic              done;
  logic              busy;
  logic [ADDR_W-1:0] a_out;
  logic [BUS_W-1:0]  ad_out;
  logic              ad_oe;
  logic [BUS_W-1:0]  ad_in;
  logic [LANES-1:0]  be_n;
  logic              ale;
  logic              rd_n;
  logic              wr_n;
  logic              inta_n;
  logic              den_n;
  logic              dtr;
  logic              iom;
  logic              ready;
  logic              hold;
  logic              hlda;

  modport master (
    output req, ctype, we, byte_op, addr, wdata, ad_in, ready, hold,
    input  rdata, done, busy, a_out, ad_out, ad_oe, be_n, ale, rd_n, wr_n,
           inta_n, den_n, dtr, iom, hlda
  );

  modport slave (
    input  req, ctype, we, byte_op, addr, wdata, ad_in, ready, hold,
    output rdata, done, busy, a_out, ad_out, ad_oe, be_n, ale, rd_n, wr_n,
           inta_n, den_n, dtr, iom, hlda
  );

endinterface

// File: rtl/bus_beat_plan.sv
// Per-beat lane, address, byte-enable and write-data placement derived from
// the latched request and the current beat index.
module bus_beat_plan
  import bus_cycle_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int BUS_W  = 8,
  parameter int CORE_W = 16,
  localparam int LANES = BUS_W / 8
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [CORE_W-1:0] i_wdata,
  input  logic              i_byte_op,
  input  logic              i_inta,
  input  logic              i_beat,
  output logic [1:0]        o_nbeats,
  output logic [ADDR_W-1:0] o_beat_addr,
  output logic [LANES-1:0]  o_be_n,
  output logic [BUS_W-1:0]  o_wbus,
  output logic              o_lane,
  output logic              o_byte_hi,
  output logic              o_full
);
  logic [7:0] w_byte;

  assign o_nbeats    = beat_count(BUS_W, i_inta, i_byte_op, i_addr[0]);
  assign o_beat_addr = i_addr + ADDR_W'(i_beat);
  assign o_lane      = beat_lane(BUS_W, i_inta, i_addr[0], i_beat);
  assign o_full      = (BUS_W == 16) && !i_inta && !i_byte_op && !i_addr[0];
  // Second beat of a split word carries the core's high byte
  assign o_byte_hi   = !(i_byte_op || i_inta) && i_beat;
  assign w_byte      = o_byte_hi ? i_wdata[15:8] : i_wdata[7:0];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign o_be_n[l]       = !(o_full || (o_lane == 1'(l)));
    assign o_wbus[l*8 +: 8] = o_full ? i_wdata[l*8 +: 8] :
                              (o_lane == 1'(l)) ? w_byte : 8'h00;
  end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// T1-T4 bus-cycle sequencer: splits core transfers into beats, inserts
// ready wait states, runs interrupt-acknowledge pairs and grants hold.
module bus_cycle_ctrl
  import bus_cycle_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int BUS_W  = 8,
  parameter int CORE_W = 16
) (
  input logic             clk,
  input logic             rst,
  bus_cycle_ctrl_if.slave bus
);
  localparam int LANES = BUS_W / 8;

  state_t            r_state, w_next;
  logic              r_we, r_byte_op, r_io, r_inta, r_beat;
  logic [ADDR_W-1:0] r_addr, r_a_out;
  logic [CORE_W-1:0] r_wdata, r_rdata;

  logic [1:0]        w_nbeats;
  logic [ADDR_W-1:0] w_beat_addr;
  logic [LANES-1:0]  w_be_n;
  logic [BUS_W-1:0]  w_wbus;
  logic              w_lane, w_byte_hi, w_full;
  logic              w_accept, w_more, w_capture;
  logic [7:0]        w_in_byte;

  bus_beat_plan #(.ADDR_W(ADDR_W), .BUS_W(BUS_W), .CORE_W(CORE_W)) u_plan (
    .i_addr     (r_addr),
    .i_wdata    (r_wdata),
    .i_byte_op  (r_byte_op),
    .i_inta     (r_inta),
    .i_beat     (r_beat),
    .o_nbeats   (w_nbeats),
    .o_beat_addr(w_beat_addr),
    .o_be_n     (w_be_n),
    .o_wbus     (w_wbus),
    .o_lane     (w_lane),
    .o_byte_hi  (w_byte_hi),
    .o_full     (w_full)
  );

  assign w_accept  = (r_state == S_IDLE) && !bus.hold && bus.req;
  assign w_more    = !r_beat && (w_nbeats == 2'd2);
  // Only the second acknowledge beat carries the vector
  assign w_capture = ((r_state == S_T3) || (r_state == S_TW)) && bus.ready &&
                     (r_inta ? r_beat : !r_we);
  assign w_in_byte = (LANES > 1 && w_lane) ? bus.ad_in[BUS_W-1 -: 8] : bus.ad_in[7:0];

  assign bus.rdata = r_rdata;
  assign bus.a_out = r_a_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we <= 1'b0; r_byte_op <= 1'b0; r_io <= 1'b0; r_inta <= 1'b0; r_beat <= 1'b0;
      r_addr <= '0; r_a_out <= '0; r_wdata <= '0; r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_we      <= bus.we;
        r_byte_op <= bus.byte_op;
        r_io      <= (bus.ctype == CT_IO);
        r_inta    <= (bus.ctype == CT_INTA);
        r_addr    <= bus.addr;
        r_wdata   <= bus.wdata;
        r_beat    <= 1'b0;
        r_a_out   <= bus.addr;
        if (!bus.we || bus.ctype == CT_INTA) r_rdata <= '0;
      end else if (r_state == S_T4 && w_more) begin
        r_beat  <= 1'b1;
        r_a_out <= w_beat_addr + ADDR_W'(1);
      end
      if (w_capture) begin
        if (w_full)         r_rdata       <= {bus.ad_in[BUS_W-1 -: 8], bus.ad_in[7:0]};
        else if (w_byte_hi) r_rdata[15:8] <= w_in_byte;
        else                r_rdata[7:0]  <= w_in_byte;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    bus.ale    = 1'b0;
    bus.ad_oe  = 1'b0;
    bus.ad_out = '0;
    bus.be_n   = '1;
    bus.rd_n   = 1'b1;
    bus.wr_n   = 1'b1;
    bus.inta_n = 1'b1;
    bus.den_n  = 1'b1;
    bus.dtr    = 1'b0;
    bus.iom    = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.hlda   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.hold)     w_next = S_HOLD;
        else if (bus.req) w_next = S_T1;
      end
      S_HOLD: begin
        bus.hlda = 1'b1;
        if (!bus.hold) w_next = S_IDLE;
      end
      default: begin
        bus.busy = 1'b1;
        bus.be_n = w_be_n;
        bus.iom  = r_io;
        bus.dtr  = r_we && !r_inta;
        case (r_state)
          S_T1: begin
            w_next     = S_T2;
            bus.ale    = 1'b1;
            bus.ad_oe  = 1'b1;
            bus.ad_out = w_beat_addr[BUS_W-1:0];
          end
          S_T2, S_T3, S_TW: begin
            if (r_state == S_T2) w_next = S_T3;
            else if (bus.ready)  w_next = S_T4;
            else                 w_next = S_TW;
            bus.den_n  = 1'b0;
            bus.rd_n   = r_inta || r_we;
            bus.wr_n   = r_inta || !r_we;
            bus.inta_n = !r_inta;
            if (r_we && !r_inta) begin
              bus.ad_oe  = 1'b1;
              bus.ad_out = w_wbus;
            end
          end
          S_T4: begin
            w_next   = w_more ? S_T1 : S_IDLE;
            bus.done = !w_more;
          end
          default: w_next = S_IDLE;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl on an 8-bit and a 16-bit external bus.
module tb_bus_cycle_ctrl;
  import bus_cycle_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bus_cycle_ctrl_if #(.ADDR_W(20), .BUS_W(8))  i8  ();
  bus_cycle_ctrl_if #(.ADDR_W(20), .BUS_W(16)) i16 ();

  bus_cycle_ctrl #(.ADDR_W(20), .BUS_W(8))  dut8  (.clk(clk), .rst(rst), .bus(i8));
  bus_cycle_ctrl #(.ADDR_W(20), .BUS_W(16)) dut16 (.clk(clk), .rst(rst), .bus(i16));

  task automatic idle_inputs;
    i8.req = 0;  i8.ctype = CT_MEM;  i8.we = 0;  i8.byte_op = 0;  i8.addr = '0;
    i8.wdata = '0;  i8.ad_in = '0;  i8.ready = 1;  i8.hold = 0;
    i16.req = 0; i16.ctype = CT_MEM; i16.we = 0; i16.byte_op = 0; i16.addr = '0;
    i16.wdata = '0; i16.ad_in = '0; i16.ready = 1; i16.hold = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_chk++; if ({i8.ale, i8.ad_oe, i8.dtr, i8.iom, i8.busy, i8.done, i8.hlda} !== 7'b0) begin n_fail++; $display("FAIL rst_ctl8: got %b want 0000000", {i8.ale, i8.ad_oe, i8.dtr, i8.iom, i8.busy, i8.done, i8.hlda}); end
    n_chk++; if ({i8.rd_n, i8.wr_n, i8.inta_n, i8.den_n, i8.be_n} !== 5'b11111) begin n_fail++; $display("FAIL rst_strb8: got %b want 11111", {i8.rd_n, i8.wr_n, i8.inta_n, i8.den_n, i8.be_n}); end
    n_chk++; if ({i8.rdata, i8.a_out, i8.ad_out} !== 44'h0) begin n_fail++; $display("FAIL rst_data8: got %h want 0", {i8.rdata, i8.a_out, i8.ad_out}); end
    n_chk++; if (i16.be_n !== 2'b11) begin n_fail++; $display("FAIL rst_be16: got %b want 11", i16.be_n); end
    rst = 0;
  endtask

  task automatic test_read8;
    int dc = 0, nd = 0;
    @(negedge clk);
    i8.req = 1; i8.ctype = CT_MEM; i8.we = 0; i8.byte_op = 0; i8.addr = 20'h12345; i8.ad_in = 8'hAB;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      i8.ad_in = (c < 4) ? 8'hAB : 8'hCD;
      if (c == 1) begin
        n_chk++; if (i8.a_out !== 20'h12345) begin n_fail++; $display("FAIL rd8_aout0: got %h want 12345", i8.a_out); end
        n_chk++; if ({i8.ale, i8.ad_oe, i8.ad_out} !== {2'b11, 8'h45}) begin n_fail++; $display("FAIL rd8_t1: got %h want 345", {i8.ale, i8.ad_oe, i8.ad_out}); end
        n_chk++; if ({i8.dtr, i8.iom} !== 2'b00) begin n_fail++; $display("FAIL rd8_dir: got %b want 00", {i8.dtr, i8.iom}); end
      end
      if (c == 2) begin
        n_chk++; if ({i8.rd_n, i8.wr_n, i8.den_n, i8.ad_oe, i8.ale} !== 5'b01000) begin n_fail++; $display("FAIL rd8_t2: got %b want 01000", {i8.rd_n, i8.wr_n, i8.den_n, i8.ad_oe, i8.ale}); end
      end
      if (c == 5) begin
        n_chk++; if ({i8.a_out, i8.ad_out} !== {20'h12346, 8'h46}) begin n_fail++; $display("FAIL rd8_aout1: got %h want 1234646", {i8.a_out, i8.ad_out}); end
      end
      if (c == 9) begin
        n_chk++; if (i8.busy !== 1'b0) begin n_fail++; $display("FAIL rd8_busy: got %b want 0", i8.busy); end
      end
      if (i8.done) begin nd++; if (dc == 0) dc = c; i8.req = 0; end
    end
    n_chk++; if (dc !== 8 || nd !== 1) begin n_fail++; $display("FAIL rd8_done: got cycle %0d count %0d want cycle 8 count 1", dc, nd); end
    n_chk++; if (i8.rdata !== 16'hCDAB) begin n_fail++; $display("FAIL rd8_rdata: got %h want cdab", i8.rdata); end
  endtask

  task automatic test_write16;
    int dc = 0, rdl = 0;
    @(negedge clk);
    i16.req = 1; i16.ctype = CT_MEM; i16.we = 1; i16.byte_op = 0; i16.addr = 20'h00101; i16.wdata = 16'hBEEF;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (!i16.rd_n) rdl++;
      if (c == 1) begin
        n_chk++; if ({i16.be_n, i16.ad_out, i16.dtr} !== {2'b01, 16'h0101, 1'b1}) begin n_fail++; $display("FAIL wr16_t1a: got %h want %h", {i16.be_n, i16.ad_out, i16.dtr}, {2'b01, 16'h0101, 1'b1}); end
      end
      if (c == 2) begin
        n_chk++; if ({i16.wr_n, i16.ad_oe, i16.ad_out} !== {2'b01, 16'hEF00}) begin n_fail++; $display("FAIL wr16_d0: got %h want %h", {i16.wr_n, i16.ad_oe, i16.ad_out}, {2'b01, 16'hEF00}); end
      end
      if (c == 3 || c == 7) begin
        n_chk++; if (i16.wr_n !== 1'b0) begin n_fail++; $display("FAIL wr16_t3: cycle %0d got %b want 0", c, i16.wr_n); end
      end
      if (c == 4) begin
        n_chk++; if ({i16.wr_n, i16.den_n, i16.ad_oe} !== 3'b110) begin n_fail++; $display("FAIL wr16_t4: got %b want 110", {i16.wr_n, i16.den_n, i16.ad_oe}); end
      end
      if (c == 5) begin
        n_chk++; if ({i16.a_out, i16.be_n} !== {20'h00102, 2'b10}) begin n_fail++; $display("FAIL wr16_t1b: got %h want %h", {i16.a_out, i16.be_n}, {20'h00102, 2'b10}); end
      end
      if (c == 6) begin
        n_chk++; if ({i16.wr_n, i16.be_n, i16.ad_out} !== {1'b0, 2'b10, 16'h00BE}) begin n_fail++; $display("FAIL wr16_d1: got %h want %h", {i16.wr_n, i16.be_n, i16.ad_out}, {1'b0, 2'b10, 16'h00BE}); end
      end
      if (i16.done && dc == 0) begin dc = c; i16.req = 0; end
    end
    n_chk++; if (dc !== 8 || rdl !== 0) begin n_fail++; $display("FAIL wr16_done: got cycle %0d rd_low %0d want 8 0", dc, rdl); end
  endtask

  task automatic test_read16;
    int dc = 0;
    @(negedge clk);
    i16.req = 1; i16.ctype = CT_MEM; i16.we = 0; i16.byte_op = 0; i16.addr = 20'h00300; i16.ad_in = 16'h1234;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin n_chk++; if (i16.be_n !== 2'b00) begin n_fail++; $display("FAIL rd16_be: got %b want 00", i16.be_n); end end
      if (i16.done && dc == 0) begin dc = c; i16.req = 0; end
    end
    n_chk++; if (dc !== 4 || i16.rdata !== 16'h1234) begin n_fail++; $display("FAIL rd16_word: got cycle %0d data %h want 4 1234", dc, i16.rdata); end
    dc = 0;
    i16.req = 1; i16.byte_op = 1; i16.addr = 20'h00301; i16.ad_in = 16'h5600;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin n_chk++; if (i16.be_n !== 2'b01) begin n_fail++; $display("FAIL rd16_bbe: got %b want 01", i16.be_n); end end
      if (i16.done && dc == 0) begin dc = c; i16.req = 0; end
    end
    n_chk++; if (dc !== 4 || i16.rdata !== 16'h0056) begin n_fail++; $display("FAIL rd16_byte: got cycle %0d data %h want 4 0056", dc, i16.rdata); end
    i16.byte_op = 0;
  endtask

  task automatic test_io_wait8;
    int dc = 0, rdl = 0;
    @(negedge clk);
    i8.req = 1; i8.ctype = CT_IO; i8.we = 0; i8.byte_op = 1; i8.addr = 20'h00040; i8.ad_in = 8'h5A; i8.ready = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      i8.ready = (c >= 6);
      if (!i8.rd_n) rdl++;
      if (c == 1 || c == 5) begin
        n_chk++; if (i8.iom !== 1'b1) begin n_fail++; $display("FAIL io8_iom: cycle %0d got %b want 1", c, i8.iom); end
      end
      if (i8.done && dc == 0) begin dc = c; i8.req = 0; end
    end
    n_chk++; if (dc !== 7 || rdl !== 5) begin n_fail++; $display("FAIL io8_wait: got done %0d rd_low %0d want 7 5", dc, rdl); end
    n_chk++; if (i8.rdata !== 16'h005A) begin n_fail++; $display("FAIL io8_rdata: got %h want 005a", i8.rdata); end
    i8.ready = 1; i8.byte_op = 0; i8.ctype = CT_MEM;
  endtask

  task automatic test_inta8;
    int dc = 0, pulses = 0, lowc = 0, rwl = 0;
    logic prev = 1'b1;
    @(negedge clk);
    i8.req = 1; i8.ctype = CT_INTA; i8.we = 1; i8.byte_op = 0; i8.addr = 20'h0; i8.ad_in = 8'h99;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      i8.ad_in = (c < 4) ? 8'h99 : 8'h08;
      if (!i8.inta_n) lowc++;
      if (prev && !i8.inta_n) pulses++;
      prev = i8.inta_n;
      if (!i8.rd_n || !i8.wr_n) rwl++;
      if (c == 1) begin n_chk++; if (i8.dtr !== 1'b0) begin n_fail++; $display("FAIL inta_dtr: got %b want 0", i8.dtr); end end
      if (c == 6) begin n_chk++; if ({i8.ad_oe, i8.den_n} !== 2'b00) begin n_fail++; $display("FAIL inta_oe: got %b want 00", {i8.ad_oe, i8.den_n}); end end
      if (i8.done && dc == 0) begin dc = c; i8.req = 0; end
    end
    n_chk++; if (pulses !== 2 || lowc !== 4 || rwl !== 0) begin n_fail++; $display("FAIL inta_strb: got pulses %0d low %0d rdwr %0d want 2 4 0", pulses, lowc, rwl); end
    n_chk++; if (dc !== 8 || i8.rdata !== 16'h0008) begin n_fail++; $display("FAIL inta_vec: got done %0d rdata %h want 8 0008", dc, i8.rdata); end
    i8.ctype = CT_MEM; i8.we = 0;
  endtask

  task automatic test_hold8;
    int dc = 0, alec = 0, busyc = 0;
    @(negedge clk);
    i8.hold = 1; i8.req = 1; i8.ctype = CT_MEM; i8.we = 0; i8.byte_op = 1; i8.addr = 20'h00200; i8.ad_in = 8'h77;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c <= 4 && i8.ale) alec++;
      if (c <= 4 && i8.busy) busyc++;
      if (c == 1) begin n_chk++; if (i8.hlda !== 1'b1) begin n_fail++; $display("FAIL hold_grant: got %b want 1", i8.hlda); end end
      if (c == 3) i8.hold = 0;
      if (c == 4) begin n_chk++; if (i8.hlda !== 1'b0) begin n_fail++; $display("FAIL hold_rel: got %b want 0", i8.hlda); end end
      if (i8.done && dc == 0) begin dc = c; i8.req = 0; end
    end
    n_chk++; if (alec !== 0 || busyc !== 0) begin n_fail++; $display("FAIL hold_quiet: got ale %0d busy %0d want 0 0", alec, busyc); end
    n_chk++; if (dc - 3 !== 5) begin n_fail++; $display("FAIL hold_lat: got %0d want 5 cycles after release", dc - 3); end
    i8.byte_op = 0;
  endtask

  task automatic test_wrap8;
    int dc = 0;
    @(negedge clk);
    i8.req = 1; i8.ctype = CT_MEM; i8.we = 1; i8.byte_op = 0; i8.addr = 20'hFFFFF; i8.wdata = 16'h1234;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin n_chk++; if ({i8.a_out, i8.ad_out} !== {20'hFFFFF, 8'hFF}) begin n_fail++; $display("FAIL wrap_b0: got %h want fffffff", {i8.a_out, i8.ad_out}); end end
      if (c == 2) begin n_chk++; if ({i8.ad_oe, i8.ad_out} !== {1'b1, 8'h34}) begin n_fail++; $display("FAIL wrap_d0: got %h want 134", {i8.ad_oe, i8.ad_out}); end end
      if (c == 5) begin n_chk++; if ({i8.a_out, i8.ad_out} !== 28'h0) begin n_fail++; $display("FAIL wrap_b1: got %h want 0000000", {i8.a_out, i8.ad_out}); end end
      if (c == 6) begin n_chk++; if (i8.ad_out !== 8'h12) begin n_fail++; $display("FAIL wrap_d1: got %h want 12", i8.ad_out); end end
      if (i8.done && dc == 0) begin dc = c; i8.req = 0; end
    end
    n_chk++; if (dc !== 8) begin n_fail++; $display("FAIL wrap_done: got %0d want 8", dc); end
    i8.we = 0;
  endtask

  task automatic test_reset_mid;
    int nd = 0, busyc = 0;
    @(negedge clk);
    i16.req = 1; i16.ctype = CT_MEM; i16.we = 0; i16.byte_op = 0; i16.addr = 20'h00200; i16.ready = 0;
    repeat (5) @(negedge clk);
    n_chk++; if ({i16.rd_n, i16.busy} !== 2'b01) begin n_fail++; $display("FAIL rstm_tw: got %b want 01", {i16.rd_n, i16.busy}); end
    rst = 1;
    #1;
    n_chk++; if ({i16.rd_n, i16.den_n, i16.be_n, i16.busy, i16.ad_oe, i16.done} !== 7'b1111000) begin n_fail++; $display("FAIL rstm_strb: got %b want 1111000", {i16.rd_n, i16.den_n, i16.be_n, i16.busy, i16.ad_oe, i16.done}); end
    n_chk++; if ({i16.a_out, i16.ad_out, i16.rdata} !== 52'h0) begin n_fail++; $display("FAIL rstm_data: got %h want 0", {i16.a_out, i16.ad_out, i16.rdata}); end
    @(negedge clk);
    rst = 0; i16.req = 0; i16.ready = 1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (i16.done) nd++;
      if (i16.busy) busyc++;
    end
    n_chk++; if (nd !== 0 || busyc !== 0) begin n_fail++; $display("FAIL rstm_nodone: got done %0d busy %0d want 0 0", nd, busyc); end
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(negedge clk);
    test_reset();
    test_read8();
    test_write16();
    test_read16();
    test_io_wait8();
    test_inta8();
    test_hold8();
    test_wrap8();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_cycle_ctrl.md
Name: bus_cycle_ctrl

Overview:
Parametrised external bus-cycle sequencer that sits between the 16-bit core request port and the multiplexed address/data pins. It splits core transfers into bus beats and runs T1–T4 cycles with ready-driven wait states. It also runs two-pulse interrupt-acknowledge sequences and grants the bus on hold. It generalises the fixed 8-bit, no-wait-state bus interface to 8- or 16-bit external buses with correct byte addressing and lane enables.

Parameters:
ADDR_W, 20, physical address width
BUS_W, 8, external data width; legal values 8 or 16
CORE_W, 16, core data width; fixed at 16, multiple of BUS_W
LANES, BUS_W/8, byte lanes on external bus (derived, not overridable)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active high
req  in  1  core transfer request; held until done
ctype  in  2  cycle type: 0 memory, 1 I/O, 2 interrupt-ack, 3 reserved (treated as memory)
we  in  1  1 write, 0 read (ignored for interrupt-ack)
byte_op  in  1  single-byte transfer
addr  in  ADDR_W  byte address
wdata  in  CORE_W  write data; byte ops use [7:0]
rdata  out  CORE_W  read data / interrupt vector in [7:0]
done  out  1  one-cycle completion pulse
busy  out  1  request accepted and not yet done
a_out  out  ADDR_W  latched beat address
ad_out  out  BUS_W  multiplexed address/data out
ad_oe  out  1  ad_out drive enable
ad_in  in  BUS_W  multiplexed bus input
be_n  out  LANES  active-low byte-lane enables
ale  out  1  address latch enable
rd_n  out  1  read strobe
wr_n  out  1  write strobe
inta_n  out  1  interrupt-ack strobe
den_n  out  1  data transceiver enable
dtr  out  1  1 transmit, 0 receive
iom  out  1  1 I/O cycle, 0 memory cycle
ready  in  1  external ready; low inserts wait states
hold  in  1  bus request from DMA master
hlda  out  1  hold acknowledge

Behaviour:
- Reset values: state IDLE; ale, done, busy, hlda, ad_oe, dtr, iom all 0; rd_n, wr_n, inta_n, den_n all 1; be_n all 1; rdata, a_out, ad_out all 0; beat counter 0.
- Reset asserted mid-cycle aborts the transfer immediately. No done is issued.
- States: IDLE, T1, T2, T3, TW, T4, HOLD.
- IDLE:
  - hold=1 → HOLD. Hold wins over a simultaneous req.
  - else req=1 → accept the request (latch ctype, we, byte_op, addr, wdata), then go to T1.
- T1: ale=1; ad_oe=1; ad_out=beat address low BUS_W bits; a_out=beat address; be_n valid; iom=(ctype==1); dtr=we for memory/I/O cycles, 0 for interrupt-ack.
- T2:
  - ale=0; strobe low (rd_n, wr_n, or inta_n); den_n=0.
  - Writes keep ad_oe=1 with lane-aligned data; reads and interrupt-ack set ad_oe=0.
- T3: sample ready.
  - ready=0 → TW.
  - ready=1 → capture ad_in into the active rdata lane(s) (reads and second interrupt-ack beat), then → T4.
- TW: strobes held; re-sample ready each cycle. No timeout; the sequencer waits indefinitely.
- T4: strobes and den_n high; ad_oe=0.
  - More beats remain → T1 with beat+1.
  - Last beat → done=1 for this cycle only, busy drops next cycle, → IDLE.
- Beat plan:
  - BUS_W=8: word = 2 beats at addr and addr+1, low byte first. Byte = 1 beat.
  - BUS_W=16: byte = 1 beat, active lane addr[0]. Aligned word = 1 beat, be_n=00. Odd word = 2 beats: addr (lane 1, be_n=01) then addr+1 (lane 0, be_n=10).
  - Beat addresses add modulo 2^ADDR_W, so the top address wraps to 0.
- Interrupt-ack: always 2 beats with inta_n pulses; no rd_n/wr_n. Vector is taken from ad_in[7:0] on the second beat; rdata[15:8]=0.
- Zero-wait latency: accept-edge → done = 4 cycles per beat (8 for a 2-beat transfer).
- Hold:
  - Sampled only in IDLE; never granted between beats of one transfer.
  - In HOLD: hlda=1, all outputs inactive, req ignored.
  - hold=0 → hlda=0 and IDLE next cycle; a pending req is accepted on the following IDLE cycle.
- rdata holds until the next accepted read.

Decomposition:
- Package bus_cycle_pkg:
  - state encoding enum (IDLE..HOLD)
  - ctype constants CT_MEM, CT_IO, CT_INTA
  - beat-plan helper function (beat count, lane per beat from BUS_W, byte_op, addr[0])
- One sub-module, bus_beat_plan: combinational lane/beat-address/be_n generator fed by the latched request and beat index. The FSM stays in bus_cycle_ctrl.

Test Plan:
- BUS_W=8, read word addr=0x12345, ready=1, ad_in 0xAB then 0xCD → a_out 0x12345/0x12346, done at cycle 8, rdata=0xCDAB.
- BUS_W=16, write word addr=0x00101, wdata=0xBEEF → two beats: be_n=01 with ad_out[15:8]=0xEF, then be_n=10 with ad_out[7:0]=0xBE; wr_n low in T2–T3 of each beat.
- BUS_W=8, I/O byte read with ready low 3 cycles → 3 TW cycles, iom=1, done at cycle 7.
- Interrupt-ack, ad_in=0x08 on beat 2 → inta_n pulses twice, rd_n stays 1, rdata=0x0008.
- hold and req asserted together in IDLE → hlda=1 next cycle, no ale. Release hold → transfer starts, done arrives 1+4×beats cycles after release.
- addr=0xFFFFF word on 8-bit bus → second beat a_out=0x00000. rst pulsed in TW of a transfer → all outputs return to reset values immediately, no done.
